// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder
// Ripple-carry adder whose carry chain is cut into STAGES registered segments.
// Stage k adds operand segment k with the carry registered by stage k-1; the
// not-yet-added upper operand bits are skewed forward and the finished lower
// sum bits are delayed, so a whole result leaves the last stage at once.
// Supports add/subtract, a signed-overflow flag and a valid/ready handshake.
//
// Handshake: an input transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. The whole
// pipe advances together when out_ready | ~out_valid; otherwise every stage
// and the outputs hold. in_ready equals that advance term.
//
// Optional build macro RCA_SAT_EN: on signed overflow the sum is clamped to
// the most positive / most negative value. ovf and c_out are unaffected.
module pipelined_rca_adder #(
   parameter int BIT_WIDTH = 16,
   parameter int STAGES    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] add_1,
   input  logic [BIT_WIDTH-1:0] add_2,
   input  logic                 c_in,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 c_out,
   output logic                 ovf
);

   localparam int SEG = BIT_WIDTH / STAGES;

   logic                 w_advance;
   logic [BIT_WIDTH-1:0] w_b_eff;
   logic                 w_c_eff;
   logic [BIT_WIDTH-1:0] w_sum_raw;
   logic                 w_c_msb;

   // Whole pipe moves unless a finished result is waiting on downstream.
   assign w_advance = out_ready | ~out_valid;
   assign in_ready  = w_advance;

   // Subtraction is A + ~B + ~borrow_in.
   assign w_b_eff = sub ? ~add_2 : add_2;
   assign w_c_eff = sub ^ c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be added when entering stage k.
      localparam int W_IN = BIT_WIDTH - k * SEG;
      // Sum bits complete after stage k.
      localparam int W_LO = (k + 1) * SEG;

      logic            w_v_in;
      logic [W_IN-1:0] w_a_in;
      logic [W_IN-1:0] w_b_in;
      logic            w_c_in;
      logic [SEG:0]    w_seg;
      logic            r_valid;
      logic            r_c;
      logic [W_LO-1:0] r_s;

      if (k == 0) begin : g_src
         assign w_v_in = in_valid;
         assign w_a_in = add_1;
         assign w_b_in = w_b_eff;
         assign w_c_in = w_c_eff;

         // First stage: only its own segment of the sum exists yet.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s <= '0;
            end else if (w_advance) begin
               r_s <= w_seg[SEG-1:0];
            end
         end
      end else begin : g_src
         assign w_v_in = g_stage[k-1].r_valid;
         assign w_a_in = g_stage[k-1].g_skew.r_a;
         assign w_b_in = g_stage[k-1].g_skew.r_b;
         assign w_c_in = g_stage[k-1].r_c;

         // Append this segment above the delayed lower sum bits.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s <= '0;
            end else if (w_advance) begin
               r_s <= {w_seg[SEG-1:0], g_stage[k-1].r_s};
            end
         end
      end

      assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, w_c_in};

      // Stage valid bit and carry out of this segment.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_c     <= 1'b0;
         end else if (w_advance) begin
            r_valid <= w_v_in;
            r_c     <= w_seg[SEG];
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [W_IN-SEG-1:0] r_a;
         logic [W_IN-SEG-1:0] r_b;

         // Carry the not-yet-added operand bits forward one stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_advance) begin
               r_a <= w_a_in[W_IN-1:SEG];
               r_b <= w_b_in[W_IN-1:SEG];
            end
         end
      end else begin : g_last
         logic r_cm;

         // Capture the carry into the MSB for the overflow flag.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cm <= 1'b0;
            end else if (w_advance) begin
               r_cm <= w_a_in[SEG-1] ^ w_b_in[SEG-1] ^ w_seg[SEG-1];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_valid;
   assign c_out     = g_stage[STAGES-1].r_c;
   assign w_sum_raw = g_stage[STAGES-1].r_s;
   assign w_c_msb   = g_stage[STAGES-1].g_last.r_cm;
   assign ovf       = w_c_msb ^ c_out;

`ifdef RCA_SAT_EN
   // Carry into MSB set on overflow means both operands were non-negative.
   assign sum = ovf ? (w_c_msb ? {1'b0, {(BIT_WIDTH-1){1'b1}}}
                               : {1'b1, {(BIT_WIDTH-1){1'b0}}})
                    : w_sum_raw;
`else
   assign sum = w_sum_raw;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder (BIT_WIDTH=16, STAGES=4): directed steps in
// one initial block, expected {sum,c_out,ovf} queued on acceptance and
// checked by a monitor when results leave the DUT.
module tb_pipelined_rca_adder;

  localparam int BW = 16;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] add_1;
  logic [BW-1:0] add_2;
  logic          c_in;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] sum;
  logic          c_out;
  logic          ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lat_on = 1'b0;

  logic [BW+1:0] exp_q[$];
  int            lat_q[$];

  logic [BW+1:0] hold_v;
  bit            held = 1'b0;

  pipelined_rca_adder #(.BIT_WIDTH(BW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .add_1(add_1), .add_2(add_2), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [BW+1:0] obs, input logic [BW+1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: {sum, c_out, ovf}
  function automatic logic [BW+1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic ci, input logic sb);
    logic [BW-1:0] be;
    logic          ce;
    logic [BW:0]   full;
    logic [BW-1:0] s;
    logic          o;
    be   = sb ? ~b : b;
    ce   = sb ? ~ci : ci;
    full = {1'b0, a} + {1'b0, be} + {{BW{1'b0}}, ce};
    s    = full[BW-1:0];
    o    = (a[BW-1] == be[BW-1]) && (s[BW-1] != a[BW-1]);
`ifdef RCA_SAT_EN
    if (o) s = a[BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
`endif
    return {s, full[BW], o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one operation, wait (bounded) for acceptance, queue expectation
  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic ci, input logic sb, input logic [BW+1:0] e);
    int n;
    add_1    = a;
    add_2    = b;
    c_in     = ci;
    sub      = sb;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("accept", {{(BW+1){1'b0}}, in_ready}, {{(BW+1){1'b0}}, 1'b1});
    if (in_ready) begin
      exp_q.push_back(e);
      lat_q.push_back(lat_on ? cyc : -1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          ci;
    logic          sb;
    a  = BW'($urandom_range(0, 65535));
    b  = BW'($urandom_range(0, 65535));
    ci = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    send(a, b, ci, sb, model(a, b, ci, sb));
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [BW+1:0] cur;
    logic [BW+1:0] e;
    int            t0;
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      cur = {sum, c_out, ovf};
      if (held) chk("stall_stable", cur, hold_v);
      if (!out_ready) begin
        chk("in_ready_stall", {{(BW+1){1'b0}}, in_ready}, '0);
        held   = 1'b1;
        hold_v = cur;
      end else begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_result: observed=%0h expected=none", cur);
        end else begin
          e  = exp_q.pop_front();
          t0 = lat_q.pop_front();
          chk("result", cur, e);
          if (t0 >= 0) chk("latency", (BW+2)'(cyc - t0), (BW+2)'(ST));
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    add_1     = '0;
    add_2     = '0;
    c_in      = 1'b0;
    sub       = 1'b0;

    // reset state
    #2;
    chk("reset_out_valid", {{(BW+1){1'b0}}, out_valid}, '0);
    chk("reset_outputs", {sum, c_out, ovf}, '0);
    #10 rst = 1'b0;
    tick();
    chk("in_ready_after_reset", {{(BW+1){1'b0}}, in_ready}, {{(BW+1){1'b0}}, 1'b1});

    // directed arithmetic, back-to-back, latency checked
    lat_on = 1'b1;
    send(16'd12,    16'd15, 1'b0, 1'b0, {16'd27,    1'b0, 1'b0});
    send(16'd12,    16'd15, 1'b1, 1'b0, {16'd28,    1'b0, 1'b0});
    send(16'd65534, 16'd1,  1'b1, 1'b0, {16'd0,     1'b1, 1'b0});
    send(16'd65534, 16'd1,  1'b0, 1'b0, {16'd65535, 1'b0, 1'b0});
    send(16'd5,     16'd7,  1'b0, 1'b1, {16'd65534, 1'b0, 1'b0});
    send(16'd7,     16'd5,  1'b0, 1'b1, {16'd2,     1'b1, 1'b0});
    send(16'd7,     16'd5,  1'b1, 1'b1, {16'd1,     1'b1, 1'b0});
    send(16'hFFFF,  16'd1,  1'b0, 1'b0, {16'd0,     1'b1, 1'b0});
`ifdef RCA_SAT_EN
    send(16'd32767, 16'd1,  1'b0, 1'b0, {16'd32767, 1'b0, 1'b1});
    send(16'h8000,  16'd1,  1'b0, 1'b1, {16'h8000,  1'b1, 1'b1});
`else
    send(16'd32767, 16'd1,  1'b0, 1'b0, {16'd32768, 1'b0, 1'b1});
    send(16'h8000,  16'd1,  1'b0, 1'b1, {16'h7FFF,  1'b1, 1'b1});
`endif

    // random operations with input gaps (bubbles)
    for (int i = 0; i < 10; i++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (8) tick();

    // back-pressure: 8 streamed ops with a 3-cycle out_ready drop
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    repeat (8) tick();

    // random back-pressure combined with input gaps
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        repeat (30) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      tick();
    end
    chk("drain_before_reset", (BW+2)'(exp_q.size()), '0);

    // reset mid-stream with 3 operations in flight and one held at the output
    out_ready = 1'b0;
    send(16'd100, 16'd200, 1'b0, 1'b0, model(16'd100, 16'd200, 1'b0, 1'b0));
    send(16'd300, 16'd400, 1'b0, 1'b0, model(16'd300, 16'd400, 1'b0, 1'b0));
    send(16'd500, 16'd600, 1'b0, 1'b0, model(16'd500, 16'd600, 1'b0, 1'b0));
    tick();
    chk("pre_reset_out_valid", {{(BW+1){1'b0}}, out_valid}, {{(BW+1){1'b0}}, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", {{(BW+1){1'b0}}, out_valid}, '0);
    chk("async_reset_outputs", {sum, c_out, ovf}, '0);
    exp_q.delete();
    lat_q.delete();
    tick();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    lat_on    = 1'b1;
    tick();
    send(16'd1, 16'd1, 1'b0, 1'b0, {16'd2, 1'b0, 1'b0});
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      tick();
    end
    repeat (6) tick();
    chk("drain_final", (BW+2)'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined successor to the 16-bit combinational ripple-carry adder used in the FIR datapath.
- Splits the carry chain into STAGES registered segments so wide adds close timing at the filter clock.
- Adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake with back-pressure.
- Sits between the multiplier array and the accumulator tree.

Parameters:
- BIT_WIDTH, 16, operand and sum width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments. Segment width SEG = BIT_WIDTH/STAGES. Legal range 1..BIT_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block accepts an input this cycle.
- add_1  input  BIT_WIDTH  operand A.
- add_2  input  BIT_WIDTH  operand B.
- c_in  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+c_in; 1 = A-B-c_in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  BIT_WIDTH  result, modulo 2^BIT_WIDTH.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst=1): all stage valid bits, sum, c_out and ovf are cleared to 0 immediately. out_valid=0. in_ready=1 once rst deasserts. Pipeline data registers are cleared.
- Arithmetic: effective B = sub ? ~add_2 : add_2. Effective carry-in = sub ? ~c_in : c_in. Result = A + effB + cin over BIT_WIDTH+1 bits. c_out = bit BIT_WIDTH. ovf = carry into MSB XOR c_out.
- Stage k (0..STAGES-1):
  - Ripple-adds segment k of A and effB with the registered carry from stage k-1 (stage 0 uses the effective carry-in).
  - Upper operand segments are skewed forward through registers.
  - Lower sum segments are delayed so all bits emerge aligned.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stall. STAGES=1 gives one registered ripple adder.
- Throughput: one operation per cycle.
- Handshake: advance = out_ready | ~out_valid, and in_ready = advance.
  - When advance=1, every stage shifts.
  - A stage loaded while in_valid=0 carries a bubble (valid=0).
  - When advance=0, all stages and outputs hold, and sum/c_out/ovf stay stable while out_valid=1.
  - An input is accepted only on in_valid & in_ready.
- Bubble collapsing is not required. Bubbles stall behind a held output.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- Wrap-around: all-ones + 1 gives sum=0, c_out=1, ovf=0.
- Reset mid-operation: in-flight results are discarded, and no partial result is ever presented with out_valid=1.
- Inputs are sampled only on acceptance; sub and c_in travel with their operands.

Optional Feature:
- Macro: RCA_SAT_EN.
- When defined:
  - If ovf would be 1, sum is clamped to the signed limit: 0x7FFF for positive overflow, 0x8000 for negative overflow (generalised to BIT_WIDTH).
  - ovf is still reported as 1.
  - c_out is unchanged.
  - Adds no latency.
- When undefined: sum wraps modulo 2^BIT_WIDTH.

Test Plan:
- Basic add and latency (BIT_WIDTH=16, STAGES=4, out_ready=1): 12+15, c_in=0, sub=0 -> sum=27, c_out=0, ovf=0 with out_valid exactly 4 cycles later. Back-to-back 12+15, c_in=1 -> 28 on the following cycle.
- Carry across every segment: 65534+1, c_in=1 -> sum=0, c_out=1, ovf=0. 65534+1, c_in=0 -> sum=65535, c_out=0.
- Subtract mode: 5-7, sub=1, c_in=0 -> sum=65534, c_out=0. 7-5 -> sum=2, c_out=1. 7-5 with c_in=1 -> sum=1.
- Signed overflow: 32767+1 -> sum=32768 and ovf=1 without RCA_SAT_EN. With RCA_SAT_EN -> sum=32767, ovf=1. 0x8000-1 (sub) with RCA_SAT_EN -> sum=0x8000, ovf=1.
- Back-pressure:
  - Stream 8 operations and hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 while out_valid=1, outputs stable during the stall, all 8 results emerge in order with none dropped or duplicated.
  - Also run with in_valid gaps to check bubbles.
- Reset mid-stream: assert rst asynchronously, between clock edges, with 3 operations in flight -> out_valid=0 and sum=0 immediately. After release, a new 1+1 yields 2 after 4 cycles with no stale results.
